// File: rtl/sp_packet_encoder.sv
// Service-protocol packet encoder: frames H1, H2, SIZE payload words, checksum and optional sequence number.
// Latency: one strobe cycle plus the far-end done delay per word; header H1 is requested on the edge after enable.
// Backpressure: each word waits in its *_W/D_SW/D_LW state until the matching done; enable low aborts to WAIT.
module sp_packet_encoder #(
  parameter int W           = 16,
  parameter int MAX_SIZE    = 1024,
  parameter int NUM_EN      = 1,
  parameter int AUTO_REPEAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [7:0]   module_addr,
  input  logic [15:0]  size,
  input  logic [7:0]   cmd_code,
  input  logic         crc_mode,
  output logic         data_request,
  input  logic         data_done,
  input  logic [W-1:0] data_data,
  output logic         packet_request,
  input  logic         packet_done,
  output logic [W-1:0] packet_data,
  output logic         busy,
  output logic         pkt_done,
  output logic         pkt_abort,
  output logic         size_err
);

  typedef enum logic [3:0] {
    S_WAIT, S_H1_L, S_H1_W, S_H2_L, S_H2_W,
    S_D_LR, S_D_LW, S_D_SR, S_D_SW,
    S_CRC_L, S_CRC_W, S_NUM_L, S_NUM_W,
    S_IDLE, S_ERR
  } state_t;

  localparam logic [16:0] LP_MAX = 17'(MAX_SIZE);

  state_t         r_state;
  logic [15:0]    r_size;
  logic [7:0]     r_cmd;
  logic           r_mode;
  logic [15:0]    r_cnt;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_seq;
  logic [W-1:0]   r_pdata;
  logic           r_preq;
  logic           r_dreq;
  logic           r_pkt_done;
  logic           r_pkt_abort;

  logic [W-1:0]   w_h1;
  logic [W-1:0]   w_h2;
  logic [W-1:0]   w_acc_next;
  logic           w_size_big;
  logic           w_in_pkt;

  // Header words, zero-extended to W. H1 comes from live inputs because it is
  // captured into packet_data on the very edge the packet fields are latched;
  // H2 comes from the latched copies.
  always_comb begin
    w_h1        = '0;
    w_h1[15:0]  = {module_addr, size[15:8]};
    w_h2        = '0;
    w_h2[15:0]  = {r_size[7:0], r_cmd};
  end

  assign w_acc_next = r_mode ? (r_acc ^ r_pdata) : (r_acc + r_pdata);
  assign w_size_big = ({1'b0, size} > LP_MAX);
  assign w_in_pkt   = !((r_state == S_WAIT) || (r_state == S_IDLE) || (r_state == S_ERR));

  assign busy           = w_in_pkt;
  assign size_err       = (r_state == S_ERR);
  assign packet_request = r_preq;
  assign data_request   = r_dreq;
  assign packet_data    = r_pdata;
  assign pkt_done       = r_pkt_done;
  assign pkt_abort      = r_pkt_abort;

  // Packet framing FSM with registered strobes, data word, checksum and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT;
      r_size      <= '0;
      r_cmd       <= '0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_seq       <= '0;
      r_pdata     <= '0;
      r_preq      <= 1'b0;
      r_dreq      <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_abort <= 1'b0;
    end else begin
      // Strobes are single-cycle: only the transition into a strobe state raises them.
      r_preq      <= 1'b0;
      r_dreq      <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_abort <= 1'b0;
      if (!enable) begin
        // Any done arriving now is dropped; the sequence counter survives.
        r_state <= S_WAIT;
        if (w_in_pkt) r_pkt_abort <= 1'b1;
      end else begin
        case (r_state)
          S_WAIT, S_IDLE: begin
            if ((r_state == S_WAIT) || (AUTO_REPEAT != 0)) begin
              if (w_size_big) begin
                r_state <= S_ERR;
              end else begin
                r_size  <= size;
                r_cmd   <= cmd_code;
                r_mode  <= crc_mode;
                r_cnt   <= size;
                r_acc   <= '0;
                r_seq   <= r_seq + 1'b1;
                r_pdata <= w_h1;
                r_preq  <= 1'b1;
                r_state <= S_H1_L;
              end
            end
          end
          S_H1_L: begin
            r_acc   <= w_acc_next;
            r_state <= S_H1_W;
          end
          S_H1_W: begin
            if (packet_done) begin
              r_pdata <= w_h2;
              r_preq  <= 1'b1;
              r_state <= S_H2_L;
            end
          end
          S_H2_L: begin
            r_acc   <= w_acc_next;
            r_state <= S_H2_W;
          end
          S_H2_W: begin
            if (packet_done) begin
              if (r_size != 16'd0) begin
                r_dreq  <= 1'b1;
                r_cnt   <= r_cnt - 16'd1;
                r_state <= S_D_LR;
              end else begin
                r_pdata <= r_acc;
                r_preq  <= 1'b1;
                r_state <= S_CRC_L;
              end
            end
          end
          S_D_LR: begin
            r_state <= S_D_LW;
          end
          S_D_LW: begin
            // packet_data doubles as the captured payload register.
            if (data_done) begin
              r_pdata <= data_data;
              r_preq  <= 1'b1;
              r_state <= S_D_SR;
            end
          end
          S_D_SR: begin
            r_acc   <= w_acc_next;
            r_state <= S_D_SW;
          end
          S_D_SW: begin
            if (packet_done) begin
              if (r_cnt == 16'd0) begin
                r_pdata <= r_acc;
                r_preq  <= 1'b1;
                r_state <= S_CRC_L;
              end else begin
                r_dreq  <= 1'b1;
                r_cnt   <= r_cnt - 16'd1;
                r_state <= S_D_LR;
              end
            end
          end
          S_CRC_L: begin
            r_state <= S_CRC_W;
          end
          S_CRC_W: begin
            if (packet_done) begin
              if (NUM_EN != 0) begin
                r_pdata <= r_seq;
                r_preq  <= 1'b1;
                r_state <= S_NUM_L;
              end else begin
                r_pkt_done <= 1'b1;
                r_state    <= S_IDLE;
              end
            end
          end
          S_NUM_L: begin
            r_state <= S_NUM_W;
          end
          S_NUM_W: begin
            if (packet_done) begin
              r_pkt_done <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
          S_ERR: begin
            r_state <= S_ERR;
          end
          default: begin
            r_state <= S_WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sp_packet_encoder.sv
module tb_sp_packet_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: small MAX_SIZE, no auto-repeat, zero-delay far end.
  logic        a_enable, a_mode;
  logic [7:0]  a_addr, a_cmd;
  logic [15:0] a_size;
  logic        a_dreq, a_preq, a_busy, a_pkt_done, a_abort, a_serr;
  logic        a_ddone = 1'b0, a_pdone = 1'b0;
  logic [15:0] a_ddata = '0;
  logic [15:0] a_pdata;

  // Instance B: defaults with auto-repeat, 3-cycle delayed far end.
  logic        b_enable, b_mode;
  logic [7:0]  b_addr, b_cmd;
  logic [15:0] b_size;
  logic        b_dreq, b_preq, b_busy, b_pkt_done, b_abort, b_serr;
  logic        b_ddone = 1'b0, b_pdone = 1'b0;
  logic [15:0] b_ddata = '0;
  logic [15:0] b_pdata;

  sp_packet_encoder #(.W(16), .MAX_SIZE(4), .NUM_EN(1), .AUTO_REPEAT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .module_addr(a_addr), .size(a_size),
    .cmd_code(a_cmd), .crc_mode(a_mode), .data_request(a_dreq), .data_done(a_ddone),
    .data_data(a_ddata), .packet_request(a_preq), .packet_done(a_pdone), .packet_data(a_pdata),
    .busy(a_busy), .pkt_done(a_pkt_done), .pkt_abort(a_abort), .size_err(a_serr)
  );

  sp_packet_encoder #(.W(16), .MAX_SIZE(1024), .NUM_EN(1), .AUTO_REPEAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .module_addr(b_addr), .size(b_size),
    .cmd_code(b_cmd), .crc_mode(b_mode), .data_request(b_dreq), .data_done(b_ddone),
    .data_data(b_ddata), .packet_request(b_preq), .packet_done(b_pdone), .packet_data(b_pdata),
    .busy(b_busy), .pkt_done(b_pkt_done), .pkt_abort(b_abort), .size_err(b_serr)
  );

  // Far-end model A: logs pushed words, serves payload from a_pay, done one cycle after the strobe.
  logic [15:0] a_log[$];
  logic [15:0] a_pay [0:7];
  int a_nreq = 0, a_pidx = 0, a_pwait = 0, a_dwait = 0;
  always @(negedge clk) begin
    a_pdone <= 1'b0;
    a_ddone <= 1'b0;
    if (!rst_n) begin
      a_pwait <= 0; a_dwait <= 0; a_pidx <= 0;
    end else begin
      if (!a_enable) a_pidx <= 0;
      if (a_preq) begin a_log.push_back(a_pdata); a_pwait <= 1; end
      else if (a_pwait == 1) begin a_pdone <= 1'b1; a_pwait <= 0; end
      if (a_dreq) begin
        a_nreq <= a_nreq + 1; a_ddata <= a_pay[a_pidx]; a_pidx <= a_pidx + 1; a_dwait <= 1;
      end else if (a_dwait == 1) begin a_ddone <= 1'b1; a_dwait <= 0; end
    end
  end

  // Far-end model B: constant payload 0x0007, done three cycles later than the minimum.
  logic [15:0] b_log[$];
  int b_pwait = 0, b_dwait = 0;
  always @(negedge clk) begin
    b_pdone <= 1'b0;
    b_ddone <= 1'b0;
    if (!rst_n) begin
      b_pwait <= 0; b_dwait <= 0;
    end else begin
      if (b_preq) begin b_log.push_back(b_pdata); b_pwait <= 4; end
      else if (b_pwait == 1) begin b_pdone <= 1'b1; b_pwait <= 0; end
      else if (b_pwait > 1) b_pwait <= b_pwait - 1;
      if (b_dreq) begin b_ddata <= 16'h0007; b_dwait <= 4; end
      else if (b_dwait == 1) begin b_ddone <= 1'b1; b_dwait <= 0; end
      else if (b_dwait > 1) b_dwait <= b_dwait - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a packet on A, check busy shortly after, wait (bounded) for pkt_done.
  task automatic run_a(input string tag, input logic [7:0] ad, input logic [15:0] sz,
                       input logic [7:0] cm, input logic md);
    int k;
    @(negedge clk);
    a_addr = ad; a_size = sz; a_cmd = cm; a_mode = md; a_enable = 1'b1;
    @(negedge clk); @(negedge clk);
    chk({tag, "_busy"}, a_busy, 1);
    k = 0;
    while (!a_pkt_done && k < 300) begin @(negedge clk); k++; end
    chk({tag, "_pkt_done"}, a_pkt_done, 1);
  endtask

  // After pkt_done: A must stay quiet in IDLE, then leave cleanly with enable low.
  task automatic finish_a(input string tag);
    int extra;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_preq || a_dreq || a_pkt_done) extra++;
    end
    chk({tag, "_idle_quiet"}, extra, 0);
    chk({tag, "_idle_busy"}, a_busy, 0);
    a_enable = 1'b0;
    @(negedge clk);
    chk({tag, "_no_abort"}, a_abort, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nreq0, n, k, cnt;
    rst_n = 1'b0;
    a_enable = 1'b0; a_addr = '0; a_size = '0; a_cmd = '0; a_mode = 1'b0;
    b_enable = 1'b0; b_addr = '0; b_size = '0; b_cmd = '0; b_mode = 1'b0;
    for (int i = 0; i < 8; i++) a_pay[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_outs", {a_preq, a_dreq, a_busy, a_pkt_done, a_abort, a_serr, a_pdata}, 0);
    chk("rst_b_outs", {b_preq, b_dreq, b_busy, b_pkt_done, b_abort, b_serr, b_pdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: addr 0x12, size 2, cmd 0x34, sum mode, payload 1,2
    a_pay[0] = 16'h0001; a_pay[1] = 16'h0002;
    base = a_log.size(); nreq0 = a_nreq;
    run_a("t1", 8'h12, 16'd2, 8'h34, 1'b0);
    chk("t1_len", a_log.size() - base, 6);
    chk("t1_h1",  a_log[base+0], 16'h1200);
    chk("t1_h2",  a_log[base+1], 16'h0234);
    chk("t1_p0",  a_log[base+2], 16'h0001);
    chk("t1_p1",  a_log[base+3], 16'h0002);
    chk("t1_crc", a_log[base+4], 16'h1437);
    chk("t1_num", a_log[base+5], 16'h0001);
    chk("t1_dreqs", a_nreq - nreq0, 2);
    finish_a("t1");

    // T2: same packet in XOR mode
    base = a_log.size();
    run_a("t2", 8'h12, 16'd2, 8'h34, 1'b1);
    chk("t2_len", a_log.size() - base, 6);
    chk("t2_crc", a_log[base+4], 16'h1037);
    chk("t2_num", a_log[base+5], 16'h0002);
    finish_a("t2");

    // T3: zero-length packet
    base = a_log.size(); nreq0 = a_nreq;
    run_a("t3", 8'hA5, 16'd0, 8'h0F, 1'b0);
    chk("t3_len", a_log.size() - base, 4);
    chk("t3_h1",  a_log[base+0], 16'hA500);
    chk("t3_h2",  a_log[base+1], 16'h000F);
    chk("t3_crc", a_log[base+2], 16'hA50F);
    chk("t3_num", a_log[base+3], 16'h0003);
    chk("t3_dreqs", a_nreq - nreq0, 0);
    finish_a("t3");

    // T4: size = MAX_SIZE (4), sum with discarded carry
    a_pay[0] = 16'hFFFF; a_pay[1] = 16'h8001; a_pay[2] = 16'h0010; a_pay[3] = 16'h1111;
    base = a_log.size(); nreq0 = a_nreq;
    run_a("t4", 8'h01, 16'd4, 8'hFE, 1'b0);
    chk("t4_len", a_log.size() - base, 8);
    chk("t4_h1",  a_log[base+0], 16'h0100);
    chk("t4_h2",  a_log[base+1], 16'h04FE);
    chk("t4_p3",  a_log[base+5], 16'h1111);
    chk("t4_crc", a_log[base+6], 16'h971F);
    chk("t4_num", a_log[base+7], 16'h0004);
    chk("t4_dreqs", a_nreq - nreq0, 4);
    finish_a("t4");

    // T5: size = MAX_SIZE+1 -> ERR, no traffic, held until enable low
    base = a_log.size(); nreq0 = a_nreq;
    @(negedge clk);
    a_addr = 8'h77; a_size = 16'd5; a_cmd = 8'h01; a_mode = 1'b0; a_enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_size_err", a_serr, 1);
    chk("t5_busy", a_busy, 0);
    chk("t5_pushes", a_log.size() - base, 0);
    chk("t5_dreqs", a_nreq - nreq0, 0);
    a_enable = 1'b0;
    @(negedge clk);
    chk("t5_err_clear", a_serr, 0);
    chk("t5_no_abort", a_abort, 0);

    // T6: abort in D_LW after one payload word, data_done in the same cycle
    a_pay[0] = 16'h0AAA; a_pay[1] = 16'h0BBB;
    base = a_log.size();
    @(negedge clk);
    a_addr = 8'h33; a_size = 16'd2; a_cmd = 8'h44; a_mode = 1'b0; a_enable = 1'b1;
    n = 0; k = 0;
    while (n < 2 && k < 300) begin
      @(negedge clk); k++;
      if (a_dreq) n++;
    end
    chk("t6_second_dreq", n, 2);
    @(negedge clk);
    a_enable = 1'b0;
    @(posedge clk); #1;
    chk("t6_abort", a_abort, 1);
    chk("t6_busy", a_busy, 0);
    chk("t6_reqs_drop", {a_preq, a_dreq}, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_preq || a_dreq) cnt++;
    end
    chk("t6_no_more_reqs", cnt, 0);
    chk("t6_abort_pulse", a_abort, 0);
    chk("t6_pushes", a_log.size() - base, 3);
    chk("t6_p0", a_log[base+2], 16'h0AAA);

    // T7: next packet after abort; sequence continues (5 was used by the aborted one)
    a_pay[0] = 16'h0005;
    base = a_log.size();
    run_a("t7", 8'h00, 16'd1, 8'h01, 1'b1);
    chk("t7_len", a_log.size() - base, 5);
    chk("t7_h2",  a_log[base+1], 16'h0101);
    chk("t7_crc", a_log[base+3], 16'h0104);
    chk("t7_num", a_log[base+4], 16'h0006);
    finish_a("t7");

    // T8: auto-repeat with delayed done: three packets back to back
    base = b_log.size();
    @(negedge clk);
    b_addr = 8'h10; b_size = 16'd1; b_cmd = 8'h20; b_mode = 1'b0; b_enable = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 3 && k < 600) begin
      @(negedge clk); k++;
      if (b_pkt_done) cnt++;
    end
    chk("t8_pkt_dones", cnt, 3);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("t8_p%0d_h1", p),  b_log[base+5*p+0], 16'h1000);
      chk($sformatf("t8_p%0d_h2", p),  b_log[base+5*p+1], 16'h0120);
      chk($sformatf("t8_p%0d_dat", p), b_log[base+5*p+2], 16'h0007);
      chk($sformatf("t8_p%0d_crc", p), b_log[base+5*p+3], 16'h1127);
      chk($sformatf("t8_p%0d_num", p), b_log[base+5*p+4], 32'(p + 1));
    end

    // T9: asynchronous reset in the middle of the fourth packet
    k = 0;
    while (b_log.size() < base + 17 && k < 300) begin @(negedge clk); k++; end
    chk("t9_reached_mid", b_log.size() >= base + 17, 1);
    chk("t9_busy_mid", b_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t9_rst_outs", {b_preq, b_dreq, b_busy, b_pkt_done, b_abort, b_serr, b_pdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = b_log.size();
    k = 0;
    while (!b_pkt_done && k < 300) begin @(negedge clk); k++; end
    chk("t9_pkt_done", b_pkt_done, 1);
    chk("t9_h1",  b_log[base+0], 16'h1000);
    chk("t9_num", b_log[base+4], 16'h0001);
    b_enable = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
